// File: rtl/attn_sched_pkg.sv
// Shared types and index helpers for the attention-head softmax scheduler.
package attn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } sched_state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Flat position of a softmax instance in the lane_done/lane_rst_n buses.
  function automatic int lane_idx(input int ch, input int lane, input int num_lanes);
    return ch * num_lanes + lane;
  endfunction

endpackage

// File: rtl/attn_rst_pulse.sv
// Registered one-cycle active-low local reset, fired on the rising edge of
// its cause or held low while the scheduler flushes.
module attn_rst_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic flush,
  output logic pulse_n
);

  logic trig_q, trig_d;
  logic pulse_n_q, pulse_n_d;

  always_comb begin
    trig_d    = trig;
    pulse_n_d = ~((trig & ~trig_q) | flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      pulse_n_q <= 1'b0;
    end else begin
      trig_q    <= trig_d;
      pulse_n_q <= pulse_n_d;
    end
  end

  assign pulse_n = pulse_n_q;

endmodule

// File: rtl/attn_softmax_sched.sv
// Schedules B2R tiles round-robin onto softmax lanes, drains finished rows to
// R2B in lane order, and sequences slice flush plus local resets.
module attn_softmax_sched
  import attn_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_TILES = 2,
  parameter int unsigned NUM_CH    = 2,
  parameter bit          REVERSE   = 1'b0,
  localparam int unsigned LW  = idx_w(NUM_LANES),
  localparam int unsigned TW  = idx_w(NUM_TILES),
  localparam int unsigned NLC = NUM_CH * NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 slice_done_b2r,
  output logic                 b2r_rst_n,
  output logic [NUM_LANES-1:0] lane_valid,
  input  logic [NLC-1:0]       lane_done,
  output logic [NLC-1:0]       lane_rst_n,
  output logic [NUM_TILES-1:0] out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        out_row_idx,
  output logic [TW-1:0]        out_tile_idx,
  output logic [NUM_TILES-1:0] slice_last,
  output logic                 busy
);

  localparam logic [LW-1:0] ROW_FIRST = REVERSE ? LW'(NUM_LANES - 1) : '0;
  localparam logic [LW-1:0] ROW_LAST  = REVERSE ? '0 : LW'(NUM_LANES - 1);
  localparam logic [TW-1:0] TILE_LAST = TW'(NUM_TILES - 1);

  // Lane pointer and drain row walk the same circular order.
  function automatic logic [LW-1:0] step(input logic [LW-1:0] p);
    if (p == ROW_LAST) return ROW_FIRST;
    return REVERSE ? (p - LW'(1)) : (p + LW'(1));
  endfunction

  sched_state_e         state_q, state_d;
  logic [LW-1:0]        lane_ptr_q, lane_ptr_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic                 ovld_q, ovld_d;
  logic [LW-1:0]        out_row_q, out_row_d;
  logic [TW-1:0]        out_tile_q, out_tile_d;
  logic [NUM_TILES-1:0] out_valid_q, out_valid_d;
  logic [NUM_TILES-1:0] slice_last_q, slice_last_d;
  logic                 busy_q, busy_d;

  logic [NUM_LANES-1:0] ptr_oh_c, row_oh_c;
  logic                 in_ready_c, accept_c, xfer_c, final_c, pend_nxt_c, flush_nxt_c;

  always_comb begin
    ptr_oh_c = '0;
    row_oh_c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      ptr_oh_c[i] = (lane_ptr_q == LW'(i));
      row_oh_c[i] = (out_row_q == LW'(i));
    end
    in_ready_c = rst_n & (state_q != ST_FLUSH) & ~|(pending_q & ptr_oh_c);
    accept_c   = in_valid & in_ready_c;
    xfer_c     = ovld_q & out_ready;
    final_c    = xfer_c & (out_row_q == ROW_LAST) & (out_tile_q == TILE_LAST);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    lane_ptr_d   = lane_ptr_q;
    out_row_d    = out_row_q;
    out_tile_d   = out_tile_q;
    ovld_d       = ovld_q;
    pend_nxt_c   = 1'b0;
    lane_valid_d = accept_c ? ptr_oh_c : '0;
    pending_d    = (pending_q & ~(xfer_c ? row_oh_c : '0)) | (accept_c ? ptr_oh_c : '0);

    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_STREAM;
      ST_STREAM: if (final_c)  state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (accept_c) lane_ptr_d = step(lane_ptr_q);
    if (xfer_c) begin
      out_row_d = step(out_row_q);
      if (out_row_q == ROW_LAST)
        out_tile_d = (out_tile_q == TILE_LAST) ? '0 : out_tile_q + TW'(1);
    end

    // Present the next row one cycle after its pending bit is visible.
    for (int unsigned i = 0; i < NUM_LANES; i++)
      if (out_row_d == LW'(i)) pend_nxt_c = pending_q[i];
    if (xfer_c || !ovld_q) ovld_d = pend_nxt_c;

    if (final_c) ovld_d = 1'b0;
    if (state_q == ST_FLUSH) begin
      pending_d  = '0;
      lane_ptr_d = ROW_FIRST;
      out_row_d  = ROW_FIRST;
      out_tile_d = '0;
      ovld_d     = 1'b0;
    end

    out_valid_d = '0;
    for (int unsigned t = 0; t < NUM_TILES; t++)
      out_valid_d[t] = ovld_d & (out_tile_d == TW'(t));
    slice_last_d = (out_row_d == ROW_LAST && out_tile_d == TILE_LAST) ? out_valid_d : '0;
    busy_d       = (state_d != ST_IDLE);
    flush_nxt_c  = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lane_ptr_q   <= ROW_FIRST;
      pending_q    <= '0;
      lane_valid_q <= '0;
      ovld_q       <= 1'b0;
      out_row_q    <= ROW_FIRST;
      out_tile_q   <= '0;
      out_valid_q  <= '0;
      slice_last_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_ptr_q   <= lane_ptr_d;
      pending_q    <= pending_d;
      lane_valid_q <= lane_valid_d;
      ovld_q       <= ovld_d;
      out_row_q    <= out_row_d;
      out_tile_q   <= out_tile_d;
      out_valid_q  <= out_valid_d;
      slice_last_q <= slice_last_d;
      busy_q       <= busy_d;
    end
  end

  attn_rst_pulse u_b2r_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig    (slice_done_b2r),
    .flush   (flush_nxt_c),
    .pulse_n (b2r_rst_n)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam int IDX = lane_idx(c, l, NUM_LANES);
      attn_rst_pulse u_lane_rst (
        .clk     (clk),
        .rst_n   (rst_n),
        .trig    (lane_done[IDX]),
        .flush   (flush_nxt_c),
        .pulse_n (lane_rst_n[IDX])
      );
    end
  end

  assign in_ready     = in_ready_c;
  assign lane_valid   = lane_valid_q;
  assign out_valid    = out_valid_q;
  assign out_row_idx  = out_row_q;
  assign out_tile_idx = out_tile_q;
  assign slice_last   = slice_last_q;
  assign busy         = busy_q;

endmodule
